// File: rtl/m1_out_packer_pkg.sv
// -----------------------------------------------------------------------------
// m1_pkg
// Shared definitions for the m1 output packer: packed word width, the bit
// offset and width of every m1 output field inside the word, the serializer
// state type, and helpers that build a word and select one of its bytes.
// No ports (package).
// -----------------------------------------------------------------------------
package m1_pkg;

  localparam int M1_WORD_W = 32;

  // Field placement inside the packed word (offset = LSB position).
  localparam int B1_OFF  = 0;   localparam int B1_W  = 1;
  localparam int BB1_OFF = 1;   localparam int BB1_W = 1;
  localparam int B2_OFF  = 2;   localparam int B2_W  = 1;
  localparam int BB2_OFF = 3;   localparam int BB2_W = 1;
  localparam int B4_OFF  = 4;   localparam int B4_W  = 2;
  localparam int BB4_OFF = 6;   localparam int BB4_W = 2;
  localparam int B5_OFF  = 8;   localparam int B5_W  = 2;
  localparam int BB5_OFF = 10;  localparam int BB5_W = 2;
  localparam int B7_OFF  = 12;  localparam int B7_W  = 5;
  localparam int BB7_OFF = 17;  localparam int BB7_W = 5;
  localparam int B8_OFF  = 22;  localparam int B8_W  = 5;
  localparam int BB8_OFF = 27;  localparam int BB8_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } m1_ser_state_t;

  // Build the packed word. The 5-bit fields are declared [1:5], so index 1
  // (their MSB) lands on the highest bit of its slice and numeric value is kept.
  function automatic logic [M1_WORD_W-1:0] m1_pack(
    input logic       b1,
    input logic       bb1,
    input logic       b2,
    input logic       bb2,
    input logic [1:0] b4,
    input logic [1:0] bb4,
    input logic [1:0] b5,
    input logic [1:0] bb5,
    input logic [1:5] b7,
    input logic [1:5] bb7,
    input logic [1:5] b8,
    input logic [1:5] bb8
  );
    logic [M1_WORD_W-1:0] w;
    w = {M1_WORD_W{1'b0}};
    w[B1_OFF  +: B1_W ] = b1;
    w[BB1_OFF +: BB1_W] = bb1;
    w[B2_OFF  +: B2_W ] = b2;
    w[BB2_OFF +: BB2_W] = bb2;
    w[B4_OFF  +: B4_W ] = b4;
    w[BB4_OFF +: BB4_W] = bb4;
    w[B5_OFF  +: B5_W ] = b5;
    w[BB5_OFF +: BB5_W] = bb5;
    w[B7_OFF  +: B7_W ] = b7;
    w[BB7_OFF +: BB7_W] = bb7;
    w[B8_OFF  +: B8_W ] = b8;
    w[BB8_OFF +: BB8_W] = bb8;
    return w;
  endfunction

  // Byte idx of a word, LSB byte first.
  function automatic logic [7:0] m1_byte_sel(
    input logic [M1_WORD_W-1:0] word,
    input logic [1:0]           idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/m1_out_packer_if.sv
// -----------------------------------------------------------------------------
// m1_out_packer_if
// Byte stream carrying packed m1 words to the downstream consumer.
//   byte_o        [7:0] stream data
//   byte_valid_o        data valid
//   byte_last_o         final byte of a word
//   byte_ready_i        downstream ready
// Modports: master = packer (drives data), slave = consumer (drives ready).
// -----------------------------------------------------------------------------
interface m1_out_packer_if;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_last_o;
  logic       byte_ready_i;

  modport master (
    output byte_o,
    output byte_valid_o,
    output byte_last_o,
    input  byte_ready_i
  );

  modport slave (
    input  byte_o,
    input  byte_valid_o,
    input  byte_last_o,
    output byte_ready_i
  );
endinterface

// File: rtl/m1_out_packer_fifo.sv
// -----------------------------------------------------------------------------
// m1_word_fifo
// Synchronous word FIFO with flush. Head and the entry behind it are both
// visible so the serializer can load the next word on the same edge it pops.
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous empty, overrides push/pop
//   push, push_data write request/data (accepted when not full or popping)
//   pop             read request (ignored when empty)
//   rd_data         head entry
//   rd_data_nxt     entry after the head
//   count           occupancy, full, empty
// -----------------------------------------------------------------------------
module m1_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           rd_data_nxt,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags and accepted push/pop; pointers alone cannot tell full from
  // empty, so the occupancy count decides.
  always_comb begin
    full         = (count_r == CNT_W'(DEPTH));
    empty        = (count_r == {CNT_W{1'b0}});
    do_pop_s     = pop & ~empty;
    do_push_s    = push & (~full | do_pop_s);
    rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
  end

  assign rd_data     = mem_r[rd_ptr_r];
  assign rd_data_nxt = mem_r[rd_ptr_nxt_s];
  assign count       = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/m1_out_packer.sv
// -----------------------------------------------------------------------------
// m1_out_packer
// Captures m1's b*/bb* outputs into a 32-bit word on cap_i, queues words in a
// DEPTH-entry FIFO and streams them LSB byte first over a valid/ready stream.
// dump empties everything synchronously and abandons any word in flight.
//   clk, rst_n          clock, async active-low reset
//   cap_i               capture strobe
//   b1..bb8             m1 output fields (5-bit ones indexed [1:5], 1 = MSB)
//   dump                synchronous flush, highest priority
//   stream (master)     byte_o / byte_valid_o / byte_last_o / byte_ready_i
//   level_o             words held, including the one being sent
//   overflow_o          sticky: a capture was dropped on a full FIFO
// -----------------------------------------------------------------------------
module m1_out_packer
  import m1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_i,
  input  logic                       b1,
  input  logic                       bb1,
  input  logic                       b2,
  input  logic                       bb2,
  input  logic [1:0]                 b4,
  input  logic [1:0]                 bb4,
  input  logic [1:0]                 b5,
  input  logic [1:0]                 bb5,
  input  logic [1:5]                 b7,
  input  logic [1:5]                 bb7,
  input  logic [1:5]                 b8,
  input  logic [1:5]                 bb8,
  input  logic                       dump,
  m1_out_packer_if.master            stream,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o
);

  localparam int                LVL_W   = $clog2(DEPTH+1);
  localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);

  logic [M1_WORD_W-1:0] word_s;
  logic [M1_WORD_W-1:0] head_s;
  logic [M1_WORD_W-1:0] head_nxt_s;
  logic [LVL_W-1:0]     count_s;
  logic                 full_s;
  logic                 empty_s;

  m1_ser_state_t state_r;
  m1_ser_state_t state_s;
  logic [1:0]    idx_r;
  logic [1:0]    idx_s;
  logic [7:0]    byte_r;
  logic [7:0]    byte_s;
  logic          valid_r;
  logic          valid_s;
  logic          last_r;
  logic          last_s;
  logic          ovf_r;
  logic          ovf_s;

  logic hs_s;
  logic pop_s;
  logic push_s;
  logic push_ok_s;

  assign word_s = m1_pack(b1, bb1, b2, bb2, b4, bb4, b5, bb5, b7, bb7, b8, bb8);

  // Handshake, pop on the final byte, and push acceptance (a full FIFO still
  // takes a word when its head leaves on the same edge).
  always_comb begin
    hs_s      = valid_r & stream.byte_ready_i;
    pop_s     = (state_r == SEND) & hs_s & (idx_r == 2'd3) & ~dump;
    push_s    = cap_i & ~dump;
    push_ok_s = push_s & (~full_s | pop_s);
  end

  m1_word_fifo #(
    .WIDTH (M1_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (dump),
    .push        (push_s),
    .push_data   (word_s),
    .pop         (pop_s),
    .rd_data     (head_s),
    .rd_data_nxt (head_nxt_s),
    .count       (count_s),
    .full        (full_s),
    .empty       (empty_s)
  );

  // Serializer next state; stream outputs are computed one edge ahead so they
  // leave this block straight from flops.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    byte_s  = byte_r;
    valid_s = valid_r;
    last_s  = last_r;
    if (dump) begin
      state_s = IDLE;
      idx_s   = 2'd0;
      byte_s  = 8'h00;
      valid_s = 1'b0;
      last_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            state_s = SEND;
            idx_s   = 2'd0;
            byte_s  = m1_byte_sel(head_s, 2'd0);
            valid_s = 1'b1;
            last_s  = 1'b0;
          end else begin
            state_s = IDLE;
            idx_s   = 2'd0;
            byte_s  = 8'h00;
            valid_s = 1'b0;
            last_s  = 1'b0;
          end
        end
        SEND: begin
          if (hs_s && (idx_r == 2'd3)) begin
            // Word done: continue straight into the next queued word, which
            // is either the entry behind the head or the one pushed right now.
            if (count_s > LVL_ONE) begin
              state_s = SEND;
              idx_s   = 2'd0;
              byte_s  = m1_byte_sel(head_nxt_s, 2'd0);
              valid_s = 1'b1;
              last_s  = 1'b0;
            end else if (push_ok_s) begin
              state_s = SEND;
              idx_s   = 2'd0;
              byte_s  = m1_byte_sel(word_s, 2'd0);
              valid_s = 1'b1;
              last_s  = 1'b0;
            end else begin
              state_s = IDLE;
              idx_s   = 2'd0;
              byte_s  = 8'h00;
              valid_s = 1'b0;
              last_s  = 1'b0;
            end
          end else if (hs_s) begin
            idx_s  = idx_r + 2'd1;
            byte_s = m1_byte_sel(head_s, idx_r + 2'd1);
            last_s = (idx_r == 2'd2);
          end else begin
            // Stalled: everything holds.
            idx_s  = idx_r;
            byte_s = byte_r;
            last_s = last_r;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 2'd0;
          byte_s  = 8'h00;
          valid_s = 1'b0;
          last_s  = 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: set on a dropped capture, cleared only by dump.
  always_comb begin
    if (dump) begin
      ovf_s = 1'b0;
    end else if (push_s && !push_ok_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Serializer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      byte_r  <= byte_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      ovf_r   <= ovf_s;
    end
  end

  assign stream.byte_o       = byte_r;
  assign stream.byte_valid_o = valid_r;
  assign stream.byte_last_o  = last_r;
  assign level_o             = count_s;
  assign overflow_o          = ovf_r;

endmodule

// File: tb/tb_m1_out_packer.sv
// -----------------------------------------------------------------------------
// tb_m1_out_packer
// Self-checking bench for m1_out_packer (DEPTH = 4). Expected bytes are pushed
// to a queue when a capture is driven and popped on each stream handshake.
// -----------------------------------------------------------------------------
module tb_m1_out_packer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cap_i = 1'b0;
  logic       dump = 1'b0;
  logic       b1, bb1, b2, bb2;
  logic [1:0] b4, bb4, b5, bb5;
  logic [1:5] b7, bb7, b8, bb8;
  logic [2:0] level_o;
  logic       overflow_o;

  m1_out_packer_if bus();

  int         errors = 0;
  int         checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got;
  logic [8:0] exp;

  always #5 clk = ~clk;

  m1_out_packer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (cap_i),
    .b1         (b1),
    .bb1        (bb1),
    .b2         (b2),
    .bb2        (bb2),
    .b4         (b4),
    .bb4        (bb4),
    .b5         (b5),
    .bb5        (bb5),
    .b7         (b7),
    .bb7        (bb7),
    .b8         (b8),
    .bb8        (bb8),
    .dump       (dump),
    .stream     (bus),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Drive the m1 fields so that the spec packing yields word w.
  task automatic drive_fields(input logic [31:0] w);
    {bb8, b8, bb7, b7, bb5, b5, bb4, b4, bb2, b2, bb1, b1} = w;
  endtask

  // Expected stream for one word: {last, byte}, LSB byte first.
  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, w[8*i +: 8]});
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cap_i = 1'b0; dump = 1'b0; bus.byte_ready_i = 1'b0;
    drive_fields(32'h0);
    #12;
    checks++; if (bus.byte_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.byte_valid_o); end
    checks++; if (bus.byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", bus.byte_o); end
    checks++; if (bus.byte_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", bus.byte_last_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    @(negedge clk); rst_n = 1'b1;
    cyc; cyc;
    checks++; if (bus.byte_valid_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL reset_idle: got valid=%b level=%0d want 0/0", bus.byte_valid_o, level_o); end
  endtask

  task automatic test_pack;
    int hs = 0;
    drive_fields(32'h0);
    b1 = 1'b1; bb4 = 2'b10; b7 = 5'b10001; bb8 = 5'b11111;
    bus.byte_ready_i = 1'b1; cap_i = 1'b1;
    push_word(32'hF8011081);
    cyc; cap_i = 1'b0;
    checks++; if (bus.byte_valid_o !== 1'b0 || level_o !== 3'd1) begin errors++; $display("FAIL pack_lat0: got valid=%b level=%0d want 0/1", bus.byte_valid_o, level_o); end
    cyc;
    checks++; if (bus.byte_valid_o !== 1'b1) begin errors++; $display("FAIL pack_lat1: got valid=%b want 1", bus.byte_valid_o); end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL pack_byte: got %h want %h", got, exp); end
      end
      cyc;
    end
    checks++; if (hs != 4 || exp_q.size() != 0) begin errors++; $display("FAIL pack_count: got %0d handshakes want 4", hs); end
    checks++; if (bus.byte_valid_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL pack_drain: got valid=%b level=%0d want 0/0", bus.byte_valid_o, level_o); end
  endtask

  task automatic test_overflow;
    logic [31:0] w;
    int hs = 0;
    bus.byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom(); w[2:0] = i[2:0];
      drive_fields(w); cap_i = 1'b1;
      if (i < 4) push_word(w);
      cyc;
    end
    cap_i = 1'b0;
    checks++; if (level_o !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
    cyc;
    bus.byte_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL ovf_byte: got %h want %h", got, exp); end
      end
      cyc;
    end
    checks++; if (hs != 16 || exp_q.size() != 0) begin errors++; $display("FAIL ovf_count: got %0d handshakes want 16", hs); end
    cyc;
    checks++; if (level_o !== 3'd0 || bus.byte_valid_o !== 1'b0) begin errors++; $display("FAIL ovf_extra: got level=%0d valid=%b want 0/0", level_o, bus.byte_valid_o); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
  endtask

  task automatic test_stall;
    logic [6:0] pat = 7'b1001101;
    logic [31:0] w;
    logic [8:0] prev = 9'h0;
    logic held = 1'b0;
    int hs = 0;
    bus.byte_ready_i = 1'b0;
    w = $urandom(); drive_fields(w); cap_i = 1'b1; push_word(w);
    cyc; cap_i = 1'b0;
    cyc;
    for (int k = 0; k < 7; k++) begin
      bus.byte_ready_i = pat[6-k];
      got = {bus.byte_last_o, bus.byte_o};
      if (held) begin
        checks++; if (got !== prev || bus.byte_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h want %h", got, prev); end
      end
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 9'h1FF; hs++; held = 1'b0;
        checks++; if (got !== exp) begin errors++; $display("FAIL stall_byte: got %h want %h", got, exp); end
      end else begin
        held = bus.byte_valid_o; prev = got;
      end
      cyc;
    end
    bus.byte_ready_i = 1'b0;
    checks++; if (hs != 4 || exp_q.size() != 0) begin errors++; $display("FAIL stall_count: got %0d handshakes want 4", hs); end
    checks++; if (level_o !== 3'd0 || bus.byte_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain: got level=%0d valid=%b want 0/0", level_o, bus.byte_valid_o); end
  endtask

  task automatic test_dump;
    logic [31:0] w;
    int hs = 0;
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL dump_pre: got overflow=%b want 1", overflow_o); end
    bus.byte_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom(); drive_fields(w); cap_i = 1'b1; push_word(w);
      cyc;
    end
    cap_i = 1'b0;
    bus.byte_ready_i = 1'b1;
    for (int c = 0; c < 6 && hs < 2; c++) begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL dump_byte: got %h want %h", got, exp); end
      end
      cyc;
    end
    checks++; if (hs != 2) begin errors++; $display("FAIL dump_pre_count: got %0d handshakes want 2", hs); end
    bus.byte_ready_i = 1'b0; dump = 1'b1; cap_i = 1'b1;
    cyc;
    dump = 1'b0; cap_i = 1'b0; exp_q.delete();
    checks++; if (bus.byte_valid_o !== 1'b0 || bus.byte_last_o !== 1'b0) begin errors++; $display("FAIL dump_valid: got valid=%b last=%b want 0/0", bus.byte_valid_o, bus.byte_last_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("FAIL dump_level: got %0d want 0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL dump_overflow: got %b want 0", overflow_o); end
    cyc; cyc;
    checks++; if (bus.byte_valid_o !== 1'b0 || level_o !== 3'd0) begin errors++; $display("FAIL dump_cap_discard: got valid=%b level=%0d want 0/0", bus.byte_valid_o, level_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    logic injected = 1'b0;
    logic inj_chk = 1'b0;
    int gaps = 0;
    int hs = 0;
    bus.byte_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom(); w[1:0] = i[1:0]; drive_fields(w); cap_i = 1'b1; push_word(w);
      cyc;
    end
    cap_i = 1'b0;
    checks++; if (level_o !== 3'd4 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_full: got level=%0d ovf=%b want 4/0", level_o, overflow_o); end
    bus.byte_ready_i = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (inj_chk) begin
        inj_chk = 1'b0;
        checks++; if (level_o !== 3'd4 || overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_pushpop: got level=%0d ovf=%b want 4/0", level_o, overflow_o); end
      end
      if (!bus.byte_valid_o) gaps++;
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL b2b_byte: got %h want %h", got, exp); end
        if (!injected && got[8]) begin
          w = $urandom(); drive_fields(w); cap_i = 1'b1; push_word(w);
          injected = 1'b1; inj_chk = 1'b1;
        end
      end
      cyc;
      cap_i = 1'b0;
    end
    checks++; if (hs != 20 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d handshakes want 20", hs); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d idle cycles want 0", gaps); end
    checks++; if (level_o !== 3'd0 || bus.byte_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got level=%0d valid=%b want 0/0", level_o, bus.byte_valid_o); end
  endtask

  task automatic test_async_reset;
    logic [31:0] w;
    int hs = 0;
    bus.byte_ready_i = 1'b1;
    w = $urandom(); drive_fields(w); cap_i = 1'b1; push_word(w);
    cyc; cap_i = 1'b0;
    cyc;
    for (int c = 0; c < 6 && hs < 2; c++) begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL arst_pre_byte: got %h want %h", got, exp); end
      end
      cyc;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.byte_valid_o !== 1'b0 || bus.byte_last_o !== 1'b0 || bus.byte_o !== 8'h00) begin errors++; $display("FAIL arst_stream: got valid=%b last=%b byte=%h want 0/0/00", bus.byte_valid_o, bus.byte_last_o, bus.byte_o); end
    checks++; if (level_o !== 3'd0 || overflow_o !== 1'b0) begin errors++; $display("FAIL arst_level: got level=%0d ovf=%b want 0/0", level_o, overflow_o); end
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete(); hs = 0;
    cyc;
    w = $urandom(); drive_fields(w); cap_i = 1'b1; push_word(w);
    cyc; cap_i = 1'b0;
    cyc;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (bus.byte_valid_o && bus.byte_ready_i) begin
        got = {bus.byte_last_o, bus.byte_o}; exp = exp_q.pop_front(); hs++;
        checks++; if (got !== exp) begin errors++; $display("FAIL arst_post_byte: got %h want %h", got, exp); end
      end
      cyc;
    end
    checks++; if (hs != 4 || level_o !== 3'd0) begin errors++; $display("FAIL arst_post_count: got %0d handshakes level=%0d want 4/0", hs, level_o); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_overflow();
    test_stall();
    test_dump();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
